// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - frame layout constants and FSM state type for the SPI slave register file
package spi_pkg;

    localparam int FRAME_BITS  = 16;
    localparam int CMD_BITS    = 8;
    localparam int WR_BIT      = 15;
    localparam int ADDR_MSB    = 14;
    localparam int ADDR_LSB    = 8;
    localparam int STATUS_ADDR = 0;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        HOLD
    } spi_state_e;

endpackage

// File: rtl/spi_slave_regfile_if.sv
// rtl/spi_slave_regfile_if.sv - SPI pin bundle between master and slave
interface spi_slave_regfile_if;

    logic sclk;
    logic ss_n;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output ss_n, output mosi, input miso, input miso_oe);
    modport slave  (input sclk, input ss_n, input mosi, output miso, output miso_oe);

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with registered rise/fall pulses
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    // Top bit of the chain is the previous synced value used for edge detection.
    logic [STAGES:0] r_chain;
    logic            r_rise;
    logic            r_fall;

    // The chain keeps sampling through reset so no false edge appears on release.
    always_ff @(posedge i_clk) begin
        r_chain <= (STAGES+1)'({r_chain, i_d});
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= r_chain[STAGES-1] & ~r_chain[STAGES];
            r_fall <= ~r_chain[STAGES-1] & r_chain[STAGES];
        end
    end

    assign o_q    = r_chain[STAGES-1];
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/spi_slave_regfile.sv
// rtl/spi_slave_regfile.sv - SPI mode-0 slave decoding 16-bit frames into register file accesses
// Optional: define SPI_WR_ECHO_EN to shift out the pre-write register value during write frames.
module spi_slave_regfile
    import spi_pkg::*;
#(
    parameter int NUM_REGS    = 4,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                i_clk,
    input  logic                i_s_rst,
    spi_slave_regfile_if.slave  spi,
    input  logic [DATA_W-1:0]   i_s_data_in,
    output logic [DATA_W-1:0]   o_s_data_out,
    output logic                o_wr_valid,
    output logic [6:0]          o_wr_addr,
    output logic [DATA_W-1:0]   o_wr_data,
    output logic                o_frame_err
);

    localparam int AW        = ADDR_MSB - ADDR_LSB + 1;
    localparam int CMD_SHIFT = FRAME_BITS - CMD_BITS;
    localparam int BCW       = $clog2(FRAME_BITS + 1);

    spi_state_e             r_state, w_next_state;
    logic                   w_sclk_rise, w_sclk_fall, w_unused_sclk_q;
    logic                   w_ss_q, w_ss_rise, w_ss_fall;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   w_mosi;
    logic [BCW-1:0]         r_bit_cnt;
    logic [FRAME_BITS-2:0]  r_frame;
    logic [FRAME_BITS-1:0]  w_frame_next;
    logic [AW-1:0]          w_lat_addr, w_wr_addr;
    logic                   w_lat_cmd, w_end_frame, w_abort, w_wr_ok, w_tx_en_next;
    logic [DATA_W-1:0]      r_tx, w_rd_value;
    logic                   r_tx_en, r_miso, r_miso_oe, r_wr_valid, r_frame_err;
    logic [AW-1:0]          r_wr_addr;
    logic [DATA_W-1:0]      r_wr_data;
    logic [DATA_W-1:0]      r_regs [1:NUM_REGS-1];

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .i_clk(i_clk), .i_rst(i_s_rst), .i_d(spi.sclk),
        .o_q(w_unused_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .i_clk(i_clk), .i_rst(i_s_rst), .i_d(spi.ss_n),
        .o_q(w_ss_q), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    always_ff @(posedge i_clk) begin
        r_mosi_sync <= SYNC_STAGES'({r_mosi_sync, spi.mosi});
    end

    assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
    assign w_frame_next = {r_frame, w_mosi};
    // At command latch only the first byte has arrived, so the fields sit CMD_SHIFT bits lower.
    assign w_lat_addr   = w_frame_next[ADDR_MSB-CMD_SHIFT:ADDR_LSB-CMD_SHIFT];
    assign w_wr_addr    = w_frame_next[ADDR_MSB:ADDR_LSB];
    assign w_wr_ok      = w_frame_next[WR_BIT] && (w_wr_addr != AW'(STATUS_ADDR))
                          && (int'(w_wr_addr) < NUM_REGS);

`ifdef SPI_WR_ECHO_EN
    assign w_tx_en_next = 1'b1;
`else
    assign w_tx_en_next = ~w_frame_next[WR_BIT-CMD_SHIFT];
`endif

    always_comb begin
        w_rd_value = '0;
        if (w_lat_addr == AW'(STATUS_ADDR)) w_rd_value = i_s_data_in;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (w_lat_addr == AW'(i)) w_rd_value = r_regs[i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_s_rst) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    // A slave-select rise outranks an sclk rise arriving in the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_lat_cmd    = 1'b0;
        w_end_frame  = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: if (w_ss_fall) w_next_state = CMD;
            CMD: begin
                if (w_ss_rise) begin
                    w_next_state = IDLE;
                    w_abort      = 1'b1;
                end else if (w_sclk_rise && r_bit_cnt == BCW'(CMD_BITS - 1)) begin
                    w_next_state = DATA;
                    w_lat_cmd    = 1'b1;
                end
            end
            DATA: begin
                if (w_ss_rise) begin
                    w_next_state = IDLE;
                    w_abort      = 1'b1;
                end else if (w_sclk_rise && r_bit_cnt == BCW'(FRAME_BITS - 1)) begin
                    w_next_state = HOLD;
                    w_end_frame  = 1'b1;
                end
            end
            HOLD: if (w_ss_rise) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            r_bit_cnt   <= '0;
            r_frame     <= '0;
            r_tx        <= '0;
            r_tx_en     <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
            for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_err <= w_abort;
            r_miso_oe   <= ~w_ss_q;
            if (r_state == IDLE && w_ss_fall) r_bit_cnt <= '0;
            if ((r_state == CMD || r_state == DATA) && w_sclk_rise) begin
                r_bit_cnt <= r_bit_cnt + BCW'(1);
                r_frame   <= w_frame_next[FRAME_BITS-2:0];
            end
            if (w_lat_cmd) begin
                r_tx    <= w_rd_value;
                r_tx_en <= w_tx_en_next;
            end
            if (r_state == DATA && w_sclk_fall && r_tx_en) begin
                r_miso <= r_tx[DATA_W-1];
                r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
            end
            if (w_end_frame && w_wr_ok) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= w_wr_addr;
                r_wr_data  <= w_frame_next[DATA_W-1:0];
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (w_wr_addr == AW'(i)) r_regs[i] <= w_frame_next[DATA_W-1:0];
                end
            end
            if (w_end_frame || w_abort) r_miso <= 1'b0;
        end
    end

    assign spi.miso     = r_miso;
    assign spi.miso_oe  = r_miso_oe;
    assign o_s_data_out = r_regs[1];
    assign o_wr_valid   = r_wr_valid;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb/tb_spi_slave_regfile.sv - self-checking bench for spi_slave_regfile
module tb_spi_slave_regfile;

    localparam int HP = 6;

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  status;
        logic        exp_wv;
        logic [7:0]  exp_val;
        logic [7:0]  exp_dout;
    } vec_t;

    logic       clk = 1'b0;
    logic       s_rst = 1'b1;
    logic [7:0] s_data_in = 8'h00;
    logic [7:0] s_data_out, wr_data;
    logic [6:0] wr_addr;
    logic       wr_valid, frame_err;

    spi_slave_regfile_if spi_if();

    spi_slave_regfile #(.NUM_REGS(4), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_s_rst(s_rst), .spi(spi_if),
        .i_s_data_in(s_data_in), .o_s_data_out(s_data_out),
        .o_wr_valid(wr_valid), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wv_cnt = 0, fe_cnt = 0, wv_cyc = 0, rise_cyc = 0, wv_base = 0, fe_base = 0;
    logic [6:0] wv_addr = '0;
    logic [7:0] wv_data = '0;
    always @(negedge clk) begin
        if (wr_valid) begin
            wv_cnt  = wv_cnt + 1;
            wv_addr = wr_addr;
            wv_data = wr_data;
            wv_cyc  = cyc;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
    end

    int n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b, output logic m);
        spi_if.mosi = b;
        tick(HP);
        spi_if.sclk = 1'b1;
        rise_cyc = cyc;
        m = spi_if.miso;
        tick(HP);
        spi_if.sclk = 1'b0;
    endtask

    task automatic xfer(input logic [15:0] f, input int nbits, output logic [7:0] rx);
        logic m;
        rx = 8'h00;
        wv_base = wv_cnt;
        fe_base = fe_cnt;
        spi_if.ss_n = 1'b0;
        tick(HP);
        for (int i = 0; i < nbits; i++) begin
            shift_bit(f[15-i], m);
            if (i >= 8) rx = {rx[6:0], m};
        end
    endtask

    task automatic ss_end();
        tick(HP);
        spi_if.ss_n = 1'b1;
        tick(10);
    endtask

    vec_t       vecs [14];
    logic [7:0] rx, exp_miso;

    initial begin
        vecs[0]  = '{16'h81A5, 8'h57, 1'b1, 8'h00, 8'hA5};
        vecs[1]  = '{16'h0000, 8'h57, 1'b0, 8'h57, 8'hA5};
        vecs[2]  = '{16'h823C, 8'h57, 1'b1, 8'h00, 8'hA5};
        vecs[3]  = '{16'h0200, 8'h57, 1'b0, 8'h3C, 8'hA5};
        vecs[4]  = '{16'h7F00, 8'h57, 1'b0, 8'h00, 8'hA5};
        vecs[5]  = '{16'h80FF, 8'h57, 1'b0, 8'h57, 8'hA5};
        vecs[6]  = '{16'h0000, 8'h3A, 1'b0, 8'h3A, 8'hA5};
        vecs[7]  = '{16'h8396, 8'h3A, 1'b1, 8'h00, 8'hA5};
        vecs[8]  = '{16'h8311, 8'h3A, 1'b1, 8'h96, 8'hA5};
        vecs[9]  = '{16'h0300, 8'h3A, 1'b0, 8'h11, 8'hA5};
        vecs[10] = '{16'h8577, 8'h3A, 1'b0, 8'h00, 8'hA5};
        vecs[11] = '{16'h0100, 8'h3A, 1'b0, 8'hA5, 8'hA5};
        vecs[12] = '{16'h8111, 8'h3A, 1'b1, 8'hA5, 8'h11};
        vecs[13] = '{16'h0100, 8'h3A, 1'b0, 8'h11, 8'h11};

        spi_if.sclk = 1'b0;
        spi_if.ss_n = 1'b1;
        spi_if.mosi = 1'b0;
        tick(10);
        check("rst miso", spi_if.miso, 0);
        check("rst miso_oe", spi_if.miso_oe, 0);
        check("rst wr_valid", wr_valid, 0);
        check("rst wr_addr", wr_addr, 0);
        check("rst wr_data", wr_data, 0);
        check("rst frame_err", frame_err, 0);
        check("rst s_data_out", s_data_out, 0);
        s_rst = 1'b0;
        tick(5);

        for (int i = 0; i < 14; i++) begin
            s_data_in = vecs[i].status;
            xfer(vecs[i].frame, 16, rx);
            check($sformatf("v%0d miso_oe active", i), spi_if.miso_oe, 1);
            ss_end();
`ifdef SPI_WR_ECHO_EN
            exp_miso = vecs[i].exp_val;
`else
            exp_miso = vecs[i].frame[15] ? 8'h00 : vecs[i].exp_val;
`endif
            check($sformatf("v%0d miso byte", i), rx, exp_miso);
            check($sformatf("v%0d wr_valid pulses", i), wv_cnt - wv_base, vecs[i].exp_wv);
            if (vecs[i].exp_wv) begin
                check($sformatf("v%0d wr_addr", i), wv_addr, vecs[i].frame[14:8]);
                check($sformatf("v%0d wr_data", i), wv_data, vecs[i].frame[7:0]);
                check($sformatf("v%0d wr latency", i), wv_cyc - rise_cyc, 4);
            end
            check($sformatf("v%0d frame_err", i), fe_cnt - fe_base, 0);
            check($sformatf("v%0d s_data_out", i), s_data_out, vecs[i].exp_dout);
            check($sformatf("v%0d idle miso_oe", i), spi_if.miso_oe, 0);
            check($sformatf("v%0d idle miso", i), spi_if.miso, 0);
        end

        s_data_in = 8'h57;
        xfer(16'h81CC, 11, rx);
        ss_end();
        check("abort frame_err", fe_cnt - fe_base, 1);
        check("abort wr_valid", wv_cnt - wv_base, 0);
        check("abort s_data_out", s_data_out, 8'h11);
        xfer(16'h0100, 16, rx);
        ss_end();
        check("post-abort read", rx, 8'h11);
        check("post-abort frame_err", fe_cnt - fe_base, 0);
        xfer(16'h825A, 16, rx);
        ss_end();
        check("post-abort wr_valid", wv_cnt - wv_base, 1);
        check("post-abort wr_addr", wv_addr, 7'h02);
        check("post-abort wr_data", wv_data, 8'h5A);

        xfer(16'h82EE, 12, rx);
        s_rst = 1'b1;
        tick(4);
        check("midrst miso", spi_if.miso, 0);
        check("midrst miso_oe", spi_if.miso_oe, 0);
        check("midrst wr_valid", wr_valid, 0);
        check("midrst wr_addr", wr_addr, 0);
        check("midrst wr_data", wr_data, 0);
        check("midrst frame_err", frame_err, 0);
        check("midrst s_data_out", s_data_out, 0);
        spi_if.ss_n = 1'b1;
        tick(6);
        s_rst = 1'b0;
        tick(8);
        check("midrst no frame_err", fe_cnt - fe_base, 0);
        check("midrst no write", wv_cnt - wv_base, 0);
        xfer(16'h0100, 16, rx);
        ss_end();
        check("midrst read reg1", rx, 8'h00);
        xfer(16'h0200, 16, rx);
        ss_end();
        check("midrst read reg2", rx, 8'h00);
        check("midrst read frame_err", fe_cnt - fe_base, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
